// File: rtl/truth_table_sequencer.sv
// Clocked sweep of every input combination of an N_IN-input boolean block,
// assembling its truth table and optionally comparing it against an expected table.
module truth_table_sequencer #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic [N_IN-1:0]      vec,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 table_valid,
    output logic                 match,
    output logic [N_IN:0]        mism_cnt
);

    localparam int unsigned TW = 2**N_IN;
    localparam int unsigned MW = N_IN + 1;
    localparam int unsigned WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [TW-1:0]   table_q, table_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic            valid_q, valid_d;
    logic            match_q, match_d;
    logic [MW-1:0]   mism_q, mism_d;

    logic [TW-1:0]   tbl_smp;
    logic [MW-1:0]   pop;

    // Table as it will look once the current combination is sampled, and its
    // distance from the captured expectation; only committed on the final sample.
    always_comb begin
        tbl_smp        = table_q;
        tbl_smp[vec_q] = f_in;
        pop            = '0;
        for (int unsigned i = 0; i < TW; i++) begin
            pop = pop + MW'(tbl_smp[i] ^ exp_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        table_d = table_q;
        exp_d   = exp_q;
        valid_d = valid_q;
        match_d = match_q;
        mism_d  = mism_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    wait_d  = '0;
                    table_d = '0;
                    valid_d = 1'b0;
                    match_d = 1'b0;
                    mism_d  = '0;
                    exp_d   = exp_table;
                end
            end

            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    wait_d  = '0;
                    valid_d = 1'b0;
                end else if (wait_q != WW'(SETTLE)) begin
                    wait_d = wait_q + WW'(1);
                end else begin
                    table_d = tbl_smp;
                    wait_d  = '0;
                    if (vec_q == '1) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        match_d = (tbl_smp == exp_q);
                        mism_d  = pop;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end
            end

            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    wait_d  = '0;
                    valid_d = 1'b0;
                end else if (start) begin
                    // DONE exit doubles as the IDLE sample point so a held start
                    // restarts immediately, giving one sweep every 2**N_IN*(SETTLE+1)+1 cycles.
                    state_d = DRIVE;
                    vec_d   = '0;
                    wait_d  = '0;
                    table_d = '0;
                    valid_d = 1'b0;
                    match_d = 1'b0;
                    mism_d  = '0;
                    exp_d   = exp_table;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            table_q <= '0;
            exp_q   <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            mism_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            valid_q <= valid_d;
            match_q <= match_d;
            mism_q  <= mism_d;
        end
    end

    assign vec         = vec_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign table_out   = table_q;
    assign table_valid = valid_q;
    assign match       = match_q;
    assign mism_cnt    = mism_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: three instances cover SETTLE = 1, 0 and 3.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: SETTLE=1, f = a&b | c
    logic       a_start, a_abort, a_f, a_busy, a_done, a_valid, a_match;
    logic [7:0] a_exp, a_tbl;
    logic [2:0] a_vec;
    logic [3:0] a_mism;
    assign a_f = (a_vec[2] & a_vec[1]) | a_vec[0];

    // Instance B: SETTLE=0, f = parity
    logic       b_start, b_abort, b_f, b_busy, b_done, b_valid, b_match;
    logic [7:0] b_exp, b_tbl;
    logic [2:0] b_vec;
    logic [3:0] b_mism;
    assign b_f = ^b_vec;

    // Instance C: SETTLE=3, f = parity
    logic       c_start, c_abort, c_f, c_busy, c_done, c_valid, c_match;
    logic [7:0] c_exp, c_tbl;
    logic [2:0] c_vec;
    logic [3:0] c_mism;
    assign c_f = ^c_vec;

    truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .exp_table(a_exp),
        .vec(a_vec), .f_in(a_f), .busy(a_busy), .done(a_done), .table_out(a_tbl),
        .table_valid(a_valid), .match(a_match), .mism_cnt(a_mism));

    truth_table_sequencer #(.N_IN(3), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .exp_table(b_exp),
        .vec(b_vec), .f_in(b_f), .busy(b_busy), .done(b_done), .table_out(b_tbl),
        .table_valid(b_valid), .match(b_match), .mism_cnt(b_mism));

    truth_table_sequencer #(.N_IN(3), .SETTLE(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .exp_table(c_exp),
        .vec(c_vec), .f_in(c_f), .busy(c_busy), .done(c_done), .table_out(c_tbl),
        .table_valid(c_valid), .match(c_match), .mism_cnt(c_mism));

    typedef struct {
        logic [7:0]  tbl;
        logic        m;
        logic [3:0]  mc;
        int unsigned due;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [7:0] model_and_or();
        logic [7:0] t;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v    = 3'(i);
            t[i] = (v[2] & v[1]) | v[0];
        end
        return t;
    endfunction

    function automatic logic [7:0] model_parity();
        logic [7:0] t;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v    = 3'(i);
            t[i] = ^v;
        end
        return t;
    endfunction

    // Pulses start on A for one edge; on return the bench sits at the negedge after the accept edge.
    task automatic start_a(input logic [7:0] e, input bit push);
        exp_t s;
        @(negedge clk);
        a_exp   = e;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        if (push) begin
            s.tbl = model_and_or();
            s.m   = (s.tbl == e);
            s.mc  = 4'($countones(s.tbl ^ e));
            s.due = cyc + 16;
            sbq.push_back(s);
        end
    endtask

    task automatic wait_done_a(output bit ok, output int unsigned at);
        int n;
        ok = 1'b0;
        at = 0;
        n  = 0;
        while (!ok && n < 100) begin
            if (a_done === 1'b1) begin
                ok = 1'b1;
                at = cyc;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_vec, a_tbl, a_busy, a_done, a_valid, a_match, a_mism} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got vec=%h tbl=%h busy=%b done=%b valid=%b match=%b mism=%0d, expected all 0",
                     a_vec, a_tbl, a_busy, a_done, a_valid, a_match, a_mism);
        end
        n_checks++;
        if ({b_vec, b_tbl, b_busy, b_done, b_valid, b_match, b_mism,
             c_vec, c_tbl, c_busy, c_done, c_valid, c_match, c_mism} !== '0) begin
            n_fail++;
            $display("FAIL reset_bc: got b_tbl=%h b_vec=%h c_tbl=%h c_vec=%h, expected all 0",
                     b_tbl, b_vec, c_tbl, c_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [7:0]  exps [4];
        exp_t        s;
        bit          ok;
        int unsigned at;
        exps = '{8'hEA, 8'h15, 8'h00, 8'hFF};
        foreach (exps[j]) begin
            start_a(exps[j], 1'b1);
            n_checks++;
            if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_start: got busy=%b valid=%b, expected busy=1 valid=0", a_busy, a_valid);
            end
            wait_done_a(ok, at);
            s = sbq.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL sweep_timeout: got no done, expected done at cycle %0d", s.due);
            end
            n_checks++;
            if (at !== s.due) begin
                n_fail++;
                $display("FAIL sweep_latency: got done at %0d, expected %0d", at, s.due);
            end
            n_checks++;
            if (a_tbl !== s.tbl) begin
                n_fail++;
                $display("FAIL sweep_table: got %h, expected %h", a_tbl, s.tbl);
            end
            n_checks++;
            if (a_match !== s.m || a_mism !== s.mc) begin
                n_fail++;
                $display("FAIL sweep_compare exp=%h: got match=%b mism=%0d, expected match=%b mism=%0d",
                         exps[j], a_match, a_mism, s.m, s.mc);
            end
            n_checks++;
            if (a_valid !== 1'b1 || a_vec !== 3'd7 || a_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_done_state: got valid=%b vec=%0d busy=%b, expected 1 7 1", a_valid, a_vec, a_busy);
            end
            @(negedge clk);
            n_checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_valid !== 1'b1 || a_vec !== 3'd7) begin
                n_fail++;
                $display("FAIL sweep_after: got done=%b busy=%b valid=%b vec=%0d, expected 0 0 1 7",
                         a_done, a_busy, a_valid, a_vec);
            end
        end
    endtask

    task automatic test_abort();
        int n_done;
        start_a(8'hEA, 1'b0);
        repeat (6) @(negedge clk);
        a_abort = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        a_start = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_vec !== 3'd0 || a_valid !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b vec=%0d valid=%b done=%b, expected all 0",
                     a_busy, a_vec, a_valid, a_done);
        end
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", n_done);
        end
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_vec !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b vec=%0d, expected 0 0", a_busy, a_vec);
        end
    endtask

    task automatic test_start_while_busy();
        exp_t        s;
        bit          ok;
        int unsigned at;
        int          n_done;
        start_a(8'h15, 1'b1);
        repeat (3) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (5) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done_a(ok, at);
        s = sbq.pop_front();
        n_checks++;
        if (!ok || at !== s.due) begin
            n_fail++;
            $display("FAIL busy_start_latency: got ok=%b at=%0d, expected done at %0d", ok, at, s.due);
        end
        n_checks++;
        if (a_tbl !== s.tbl || a_mism !== s.mc || a_match !== s.m) begin
            n_fail++;
            $display("FAIL busy_start_result: got tbl=%h mism=%0d match=%b, expected %h %0d %b",
                     a_tbl, a_mism, a_match, s.tbl, s.mc, s.m);
        end
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_extra: got %0d extra done, busy=%b, expected 0 0", n_done, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        s;
        bit          ok;
        int unsigned at;
        int unsigned k;
        @(negedge clk);
        a_exp   = 8'hEA;
        a_start = 1'b1;
        @(negedge clk);
        k = cyc;
        for (int j = 0; j < 3; j++) begin
            s.tbl = model_and_or();
            s.m   = (s.tbl == 8'hEA);
            s.mc  = 4'($countones(s.tbl ^ 8'hEA));
            s.due = k + 16 + 17 * j;
            sbq.push_back(s);
        end
        for (int j = 0; j < 3; j++) begin
            wait_done_a(ok, at);
            if (j == 2) a_start = 1'b0;
            s = sbq.pop_front();
            n_checks++;
            if (!ok || at !== s.due) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got ok=%b at=%0d, expected %0d", j, ok, at, s.due);
            end
            n_checks++;
            if (a_tbl !== s.tbl || a_match !== s.m) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got tbl=%h match=%b, expected %h %b", j, a_tbl, a_match, s.tbl, s.m);
            end
            @(negedge clk);
            if (j < 2) begin
                n_checks++;
                if (a_valid !== 1'b0 || a_busy !== 1'b1 || a_vec !== 3'd0) begin
                    n_fail++;
                    $display("FAIL b2b_restart[%0d]: got valid=%b busy=%b vec=%0d, expected 0 1 0",
                             j, a_valid, a_busy, a_vec);
                end
            end else begin
                n_checks++;
                if (a_busy !== 1'b0 || a_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_stop: got busy=%b valid=%b, expected 0 1", a_busy, a_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t        s;
        bit          ok;
        int unsigned at;
        start_a(8'hEA, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({a_vec, a_tbl, a_busy, a_done, a_valid, a_match, a_mism} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got vec=%h tbl=%h busy=%b done=%b valid=%b match=%b mism=%0d, expected all 0",
                     a_vec, a_tbl, a_busy, a_done, a_valid, a_match, a_mism);
        end
        start_a(8'h15, 1'b1);
        wait_done_a(ok, at);
        s = sbq.pop_front();
        n_checks++;
        if (!ok || at !== s.due || a_tbl !== s.tbl) begin
            n_fail++;
            $display("FAIL reset_restart: got ok=%b at=%0d tbl=%h, expected at=%0d tbl=%h", ok, at, a_tbl, s.due, s.tbl);
        end
        n_checks++;
        if (a_match !== s.m || a_mism !== s.mc) begin
            n_fail++;
            $display("FAIL reset_restart_cmp: got match=%b mism=%0d, expected %b %0d", a_match, a_mism, s.m, s.mc);
        end
    endtask

    task automatic test_settle();
        int unsigned k;
        int unsigned at;
        int          n;
        logic [7:0]  par;
        par = model_parity();
        @(negedge clk);
        b_exp   = par;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k  = cyc;
        at = 0;
        n  = 0;
        while (b_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (b_done === 1'b1) at = cyc;
        n_checks++;
        if (at !== k + 8) begin
            n_fail++;
            $display("FAIL settle0_latency: got done at %0d, expected %0d", at, k + 8);
        end
        n_checks++;
        if (b_tbl !== par || b_match !== 1'b1 || b_mism !== 4'd0) begin
            n_fail++;
            $display("FAIL settle0_result: got tbl=%h match=%b mism=%0d, expected %h 1 0", b_tbl, b_match, b_mism, par);
        end

        @(negedge clk);
        c_exp   = 8'h00;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int unsigned off = 0; off < 32; off++) begin
            n_checks++;
            if (c_vec !== 3'(off / 4) || c_done !== 1'b0) begin
                n_fail++;
                $display("FAIL settle3_step[%0d]: got vec=%0d done=%b, expected vec=%0d done=0",
                         off, c_vec, c_done, off / 4);
            end
            @(negedge clk);
        end
        n_checks++;
        if (c_done !== 1'b1 || cyc !== k + 0 + (cyc - k)) begin
            n_fail++;
            $display("FAIL settle3_done: got done=%b, expected 1 at 32 cycles after start", c_done);
        end
        n_checks++;
        if (c_tbl !== par || c_match !== 1'b0 || c_mism !== 4'($countones(par))) begin
            n_fail++;
            $display("FAIL settle3_result: got tbl=%h match=%b mism=%0d, expected %h 0 %0d",
                     c_tbl, c_match, c_mism, par, $countones(par));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_exp = '0;
        b_start = 1'b0; b_abort = 1'b0; b_exp = '0;
        c_start = 1'b0; c_abort = 1'b0; c_exp = '0;
        test_reset();
        test_sweep();
        test_abort();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
